pe_acc_requant_drain: RTL and testbench
=======================================

# pe_acc_requant_drain

Downstream stage of the signed 8x8 / 1x8 packed-DSP MAC PE. Captures the PE's packed accumulator word when an accumulation window completes, pulses a clear back to the PE, and unpacks the word into individual signed lanes. Each lane is requantised (bias add, rounding arithmetic right shift, optional ReLU, int8 saturation) and streamed out one lane per cycle over a valid/ready handshake toward the output buffer.

## Interface
- `HEADROOM`, default 4: accumulator guard bits per lane.
- `LANE_W_88`, default 16+HEADROOM (20): lane width in mode 0.
- `LANE_W_18`, default 10+HEADROOM (14): lane width in mode 1.
- `ACC_W`, default 4*LANE_W_18 (56): packed accumulator width.
- `BIAS_W`, default 24: signed bias width.
- `SHIFT_W`, default 5: requant shift width.
- `OUT_W`, default 8: signed output width.
- `clk` in, 1: clock.
- `reset` in, 1: reset, synchronous, active-high.
- `acc_valid` in, 1: `acc_data` holds a completed accumulation.
- `acc_ready` out, 1: block can capture (high only in IDLE).
- `acc_data` in, ACC_W: packed PE accumulator.
- `acc_mode` in, 1: 0 = 2 lanes of LANE_W_88 at offsets 0/20; 1 = 4 lanes of LANE_W_18 at offsets 0/14/28/42.
- `cfg_bias` in, BIAS_W: signed bias, same for all lanes of a word.
- `cfg_shift` in, SHIFT_W: right-shift amount, 0..31.
- `cfg_relu` in, 1: clamp negatives to 0.
- `acc_clear` out, 1: one-cycle pulse telling the PE to zero its accumulator.
- `out_valid` out, 1: output lane valid.
- `out_ready` in, 1: consumer accepts.
- `out_data` out, OUT_W: signed requantised lane.
- `out_lane` out, 2: lane index, 0 = lowest bits.
- `out_last` out, 1: final lane of the captured word.

## Operation
- States are IDLE, LOAD and DRAIN. `acc_ready` = (state == IDLE).
- Capture:
  - `acc_valid && acc_ready` at a rising edge registers `acc_data`, `acc_mode`, `cfg_bias`, `cfg_shift` and `cfg_relu` into a snapshot, sets lane=0 and moves to LOAD.
  - `acc_clear` is a registered copy of the capture handshake, so it is high the cycle after the handshake.
- Lane extraction:
  - Mode 0: lane i = `snap[20i +: 20]`, with i in 0..1.
  - Mode 1: lane i = `snap[14i +: 14]`, with i in 0..3.
  - The lane is sign-extended from its MSB.
  - Lane count N is 2 in mode 0 and 4 in mode 1. Bits [55:40] are ignored in mode 0.
- Arithmetic, computed on the current lane:
  - sum = sext26(lane) + sext26(bias).
  - rnd = sum + (shift == 0 ? 0 : 1 << (shift-1)). This rounds half toward +inf.
  - q = rnd >>> shift (arithmetic). q is all-sign-bits once shift ≥ 26.
  - If relu and q < 0, then q = 0.
  - Saturate to [-128, 127].
- LOAD: on the next edge, output registers take lane 0's result and `out_valid` = 1; go to DRAIN.
- DRAIN:
  - When `out_valid && out_ready` and lane < N-1: load lane+1's result on the same edge. This gives 1 lane per cycle with no bubble.
  - When `out_valid && out_ready` and lane == N-1: `out_valid` goes to 0 and state goes to IDLE.
  - `out_last` = (lane == N-1).
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_lane` and `out_last` hold stable.
- `acc_valid` outside IDLE is not captured. The upstream must hold it until `acc_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `acc_clear`=0, state=IDLE (so `acc_ready`=1). The snapshot is don't-care.
- Capture handshake at edge E0:
  - `acc_clear` is high for the cycle after E0.
  - `out_valid` rises after edge E0+1.
  - Latency from handshake to first lane is 2 edges.
- Throughput with `out_ready` held at 1:
  - Mode 0: 2 lanes on consecutive cycles, then IDLE.
  - Mode 1: 4 lanes on consecutive cycles, then IDLE.
  - Next capture is possible at the edge after the last lane is accepted. Minimum word period is N+2 cycles.
- Config changes after capture have no effect on the word being drained.
- Reset asserted mid-LOAD or mid-DRAIN: at that edge go to IDLE, drop `out_valid`, drop `acc_clear`, and discard the remaining lanes.
- Reset and `acc_valid` in the same cycle: reset wins and nothing is captured.

## Test plan
- Mode 0 rounding: lane0 = +300, lane1 = -5, bias 0, shift 2, relu 0. Output is 75 (lane 0), then -1 (lane 1, last). `acc_clear` pulses once the cycle after capture.
- Mode 1 unpack: lanes {0..3} = {7, -8, 100, -1}, bias 10, shift 0. Outputs 17, 2, 110, 9 with `out_lane` 0..3; `out_last` only on lane 3.
- Saturation and ReLU: mode 0, lanes +20000 and -20000, shift 0.
  - relu 0: outputs 127 and -128.
  - relu 1: outputs 127 and 0.
- Backpressure: mode 1 word with `out_ready` low for 3 cycles at lane 1.
  - Lane 1's data, index and last stay stable while stalled.
  - No lane is lost or duplicated.
  - `acc_ready` stays 0 until lane 3 is accepted.
- Config isolation and back-to-back: change `cfg_shift` from 2 to 4 during a drain, and present a second word with `acc_valid` held.
  - The first word uses shift 2; the second uses shift 4.
  - The second capture happens the edge after the first word's last-lane acceptance.
- Reset mid-DRAIN: assert reset after lane 1 of a mode 1 word. Next cycle: `out_valid`=0, `acc_ready`=1. A fresh word then drains correctly from lane 0.

Source files
------------

// File: rtl/pe_acc_requant_drain.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pe_acc_requant_drain: snapshots the packed PE accumulator, requantises each
// lane to a signed OUT_W value and streams lanes out one per cycle.
// Revision: 1.0
// -----------------------------------------------------------------------------
module pe_acc_requant_drain #(
    parameter int HEADROOM  = 4,
    parameter int LANE_W_88 = 16 + HEADROOM,
    parameter int LANE_W_18 = 10 + HEADROOM,
    parameter int ACC_W     = 4 * LANE_W_18,
    parameter int BIAS_W    = 24,
    parameter int SHIFT_W   = 5,
    parameter int OUT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [ACC_W-1:0]   acc_data,
    input  logic               acc_mode,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_relu,
    output logic               acc_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [1:0]         out_lane,
    output logic               out_last
);

    // Headroom above the 26-bit sum keeps the rounding constant exact for
    // every shift up to 31, so large shifts collapse cleanly to the sign.
    localparam int CALC_W = 26 + 8;
    localparam logic signed [CALC_W-1:0] SAT_MAX = CALC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [CALC_W-1:0] SAT_MIN = CALC_W'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0]   snap_data;
    logic               snap_mode;
    logic [BIAS_W-1:0]  snap_bias;
    logic [SHIFT_W-1:0] snap_shift;
    logic               snap_relu;
    logic [1:0]         lane;

    logic                     capture;
    logic                     fire;
    logic [1:0]               last_idx;
    logic [1:0]               sel_idx;
    logic [LANE_W_18-1:0]     raw18;
    logic [LANE_W_88-1:0]     raw88;
    logic signed [CALC_W-1:0] lane_ext;
    logic signed [CALC_W-1:0] bias_ext;
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] round_inc;
    logic signed [CALC_W-1:0] rnd;
    logic signed [CALC_W-1:0] q;
    logic signed [CALC_W-1:0] relu_q;
    logic [OUT_W-1:0]         res;

    assign acc_ready = (state == IDLE);
    assign capture   = acc_valid && acc_ready;
    assign fire      = out_valid && out_ready;
    assign last_idx  = snap_mode ? 2'd3 : 2'd1;
    assign out_lane  = lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (capture) state_nx = LOAD;
            LOAD:    state_nx = DRAIN;
            DRAIN:   if (fire && (lane == last_idx)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // In DRAIN the datapath precomputes the lane that the next accept loads.
    assign sel_idx = (state == DRAIN) ? lane + 2'd1 : lane;
    assign raw18   = snap_data[int'(sel_idx) * LANE_W_18 +: LANE_W_18];
    assign raw88   = snap_data[int'(sel_idx[0]) * LANE_W_88 +: LANE_W_88];

    assign lane_ext = snap_mode ? {{(CALC_W - LANE_W_18){raw18[LANE_W_18-1]}}, raw18}
                                : {{(CALC_W - LANE_W_88){raw88[LANE_W_88-1]}}, raw88};
    assign bias_ext  = {{(CALC_W - BIAS_W){snap_bias[BIAS_W-1]}}, snap_bias};
    assign sum       = lane_ext + bias_ext;
    assign round_inc = (snap_shift == '0) ? '0
                                          : (CALC_W'(1) << (snap_shift - SHIFT_W'(1)));
    assign rnd       = sum + round_inc;
    assign q         = rnd >>> snap_shift;
    assign relu_q    = (snap_relu && q[CALC_W-1]) ? '0 : q;

    always_comb begin
        res = relu_q[OUT_W-1:0];
        if (relu_q > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (relu_q < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            acc_clear <= 1'b0;
            lane      <= '0;
        end else begin
            acc_clear <= capture;
            case (state)
                IDLE: begin
                    if (capture) begin
                        snap_data  <= acc_data;
                        snap_mode  <= acc_mode;
                        snap_bias  <= cfg_bias;
                        snap_shift <= cfg_shift;
                        snap_relu  <= cfg_relu;
                        lane       <= '0;
                    end
                end
                LOAD: begin
                    out_valid <= 1'b1;
                    out_data  <= res;
                    out_last  <= (lane == last_idx);
                end
                DRAIN: begin
                    if (fire) begin
                        if (lane != last_idx) begin
                            lane     <= lane + 2'd1;
                            out_data <= res;
                            out_last <= ((lane + 2'd1) == last_idx);
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_acc_requant_drain.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pe_acc_requant_drain: directed and random words against an arithmetic
// reference of the requantiser.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_pe_acc_requant_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        acc_valid;
    logic        acc_ready;
    logic [55:0] acc_data;
    logic        acc_mode;
    logic [23:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_acc_requant_drain dut (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .acc_mode  (acc_mode),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the lane value.
    function automatic int ref_q(input int lane_v, input int bias, input int shift,
                                 input bit relu);
        longint r;
        r = longint'(lane_v) + longint'(bias);
        if (shift > 0) r = r + (longint'(1) << (shift - 1));
        r = r >>> shift;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic logic [55:0] pack(input bit mode, input int ln[4]);
        logic [55:0] w;
        w = 56'({$urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            if (mode) w[i*14 +: 14] = ln[i][13:0];
            else if (i < 2) w[i*20 +: 20] = ln[i][19:0];
        end
        return w;
    endfunction

    function automatic int rand_lane(input bit mode);
        if (mode) return int'($urandom_range(0, 16383)) - 8192;
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    task automatic drive(input bit mode, input int ln[4], input int bias, input int shift,
                         input bit relu, output int e[4], output int n);
        acc_mode  = mode;
        acc_data  = pack(mode, ln);
        cfg_bias  = bias[23:0];
        cfg_shift = shift[4:0];
        cfg_relu  = relu;
        acc_valid = 1'b1;
        n = mode ? 4 : 2;
        for (int i = 0; i < 4; i++) e[i] = ref_q(ln[i], bias, shift, relu);
    endtask

    // Called at a negedge with acc_valid high; the following edge must capture.
    task automatic capture();
        chk("acc_ready_idle", acc_ready, 1);
        @(negedge clk);
        chk("acc_clear_pulse", acc_clear, 1);
        chk("acc_ready_busy", acc_ready, 0);
        chk("load_no_valid", out_valid, 0);
    endtask

    task automatic collect(input int e[4], input int n, input int stall_lane,
                           input int stall_cyc, input int take);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("first_lane_latency", t, 1);
        chk("acc_clear_single", acc_clear, 0);
        for (int k = 0; k < take; k++) begin
            if (k > 0) chk("no_bubble", out_valid, 1);
            chk("lane_data", $signed(out_data), e[k]);
            chk("lane_index", out_lane, k);
            chk("lane_last", out_last, (k == n - 1));
            if (k == stall_lane) begin
                out_ready = 1'b0;
                repeat (stall_cyc) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", $signed(out_data), e[k]);
                    chk("stall_index", out_lane, k);
                    chk("stall_last", out_last, (k == n - 1));
                    chk("stall_acc_ready", acc_ready, 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        if (take == n) begin
            chk("drain_done_valid", out_valid, 0);
            chk("drain_done_ready", acc_ready, 1);
        end
    endtask

    initial begin
        int ln[4];
        int e1[4];
        int e2[4];
        int n1;
        int n2;
        bit mode;
        int bias;
        int n_lanes;

        reset     = 1'b1;
        acc_valid = 1'b0;
        acc_data  = '0;
        acc_mode  = 1'b0;
        cfg_bias  = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_acc_clear", acc_clear, 0);
        chk("rst_acc_ready", acc_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Mode 0 rounding: 75 then -1.
        ln = '{300, -5, 0, 0};
        drive(1'b0, ln, 0, 2, 1'b0, e1, n1);
        capture();
        acc_valid = 1'b0;
        chk("m0_ref_lane0", e1[0], 75);
        collect(e1, n1, -1, 0, n1);

        // Mode 1 unpack: 17, 2, 110, 9.
        ln = '{7, -8, 100, -1};
        drive(1'b1, ln, 10, 0, 1'b0, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, -1, 0, n1);

        // Saturation without and with ReLU.
        ln = '{20000, -20000, 0, 0};
        drive(1'b0, ln, 0, 0, 1'b0, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, -1, 0, n1);
        drive(1'b0, ln, 0, 0, 1'b1, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, -1, 0, n1);

        // Backpressure: three stall cycles on lane 1.
        for (int i = 0; i < 4; i++) ln[i] = rand_lane(1'b1);
        drive(1'b1, ln, 5, 3, 1'b0, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, 1, 3, n1);

        // Config isolation and back-to-back capture with acc_valid held.
        for (int i = 0; i < 4; i++) ln[i] = rand_lane(1'b1);
        drive(1'b1, ln, -37, 2, 1'b0, e1, n1);
        capture();
        for (int i = 0; i < 4; i++) ln[i] = rand_lane(1'b1);
        drive(1'b1, ln, 123, 4, 1'b0, e2, n2);
        collect(e1, n1, -1, 0, n1);
        capture();
        acc_valid = 1'b0;
        collect(e2, n2, -1, 0, n2);

        // Reset after lane 1 of a mode 1 word, then a fresh word.
        for (int i = 0; i < 4; i++) ln[i] = rand_lane(1'b1);
        drive(1'b1, ln, 0, 1, 1'b0, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, -1, 0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", acc_ready, 1);
        chk("rst_mid_clear", acc_clear, 0);
        for (int i = 0; i < 4; i++) ln[i] = rand_lane(1'b1);
        drive(1'b1, ln, 77, 6, 1'b1, e1, n1);
        capture();
        acc_valid = 1'b0;
        collect(e1, n1, -1, 0, n1);

        // Reset and acc_valid together: nothing is captured.
        ln = '{1000, 2000, 0, 0};
        drive(1'b0, ln, 0, 0, 1'b0, e1, n1);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        acc_valid = 1'b0;
        chk("rst_vs_cap_clear", acc_clear, 0);
        chk("rst_vs_cap_ready", acc_ready, 1);
        @(negedge clk);
        chk("rst_vs_cap_clear2", acc_clear, 0);
        @(negedge clk);
        chk("rst_vs_cap_valid", out_valid, 0);

        // Randomised words.
        for (int w = 0; w < 12; w++) begin
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) ln[i] = rand_lane(mode);
            if ($urandom_range(0, 1) == 1) bias = int'($urandom_range(0, 4095)) - 2048;
            else bias = int'($urandom_range(0, 16777215)) - 8388608;
            n_lanes = mode ? 4 : 2;
            drive(mode, ln, bias, int'($urandom_range(0, 25)), 1'($urandom_range(0, 1)),
                  e1, n1);
            capture();
            acc_valid = 1'b0;
            collect(e1, n1, int'($urandom_range(0, n_lanes - 1)),
                    int'($urandom_range(0, 2)), n1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
